// File: rtl/alu_pkg.sv
// Shared ALU definitions: result width, opcode encodings and the stored result record.
// Imported by the result buffer, its interface and the bench.
package alu_pkg;

    localparam int DATA_W = 12;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_AND    = 3'b010;
    localparam logic [2:0] OP_OR     = 3'b011;
    localparam logic [2:0] OP_XOR    = 3'b100;
    localparam logic [2:0] OP_MIN    = 3'b101;
    localparam logic [2:0] OP_MAX    = 3'b110;
    localparam logic [2:0] OP_ABSMAX = 3'b111;

    typedef struct packed {
        logic              ovf;
        logic [DATA_W-1:0] data;
    } alu_res_t;

endpackage

// File: rtl/alu_result_buffer_if.sv
// Bundle between the ALU/consumer side and the result buffer.
// The buffer uses the slave modport; the producer/consumer side uses master.
interface alu_result_buffer_if
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              i_overflow;
    logic              i_clr;
    logic              i_ready;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_overflow;
    logic              o_full;
    logic              o_empty;
    logic [CW-1:0]     o_count;
    logic [CNT_W-1:0]  o_drop_cnt;
    logic [CNT_W-1:0]  o_ovf_cnt;
    logic              o_ovf_sticky;

    modport master (
        output i_valid, i_data, i_overflow, i_clr, i_ready,
        input  o_valid, o_data, o_overflow, o_full, o_empty, o_count,
               o_drop_cnt, o_ovf_cnt, o_ovf_sticky
    );

    modport slave (
        input  i_valid, i_data, i_overflow, i_clr, i_ready,
        output o_valid, o_data, o_overflow, o_full, o_empty, o_count,
               o_drop_cnt, o_ovf_cnt, o_ovf_sticky
    );

endinterface

// File: rtl/alu_result_buffer_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
// clr has priority over inc so events in a clearing cycle are not counted.
module sat_counter
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/alu_result_buffer.sv
// First-word-fall-through FIFO behind the ALU. Absorbs bursts, drops and counts
// results that arrive while full, and keeps overflow statistics.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    alu_result_buffer_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("alu_result_buffer: DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic [DATA_W:0] mem_q [DEPTH];
    logic [PW-1:0]   rdPtr_q, rdPtr_d;
    logic [PW-1:0]   wrPtr_q, wrPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            sticky_q, sticky_d;

    logic            full;
    logic            empty;
    logic            pop;
    logic            push;
    logic            drop;
    logic [DATA_W:0] headEntry;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && bus.i_ready;
    // A full FIFO still accepts a result when the head leaves in the same cycle.
    assign push  = bus.i_valid && (!full || pop);
    assign drop  = bus.i_valid && full && !pop;

    always_comb begin
        rdPtr_d  = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
        wrPtr_d  = push ? wrPtr_q + PW'(1) : wrPtr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        sticky_d = sticky_q;
        if (bus.i_clr) begin
            sticky_d = 1'b0;
        end else if (bus.i_valid && bus.i_overflow) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdPtr_q  <= '0;
            wrPtr_q  <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            rdPtr_q  <= rdPtr_d;
            wrPtr_q  <= wrPtr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            mem_q[wrPtr_q] <= {bus.i_overflow, bus.i_data};
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .clr   (bus.i_clr),
        .inc   (drop),
        .count (bus.o_drop_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .clr   (bus.i_clr),
        .inc   (push && bus.i_overflow),
        .count (bus.o_ovf_cnt)
    );

    assign headEntry        = mem_q[rdPtr_q];
    assign bus.o_valid      = !empty;
    assign bus.o_data       = empty ? '0 : headEntry[DATA_W-1:0];
    assign bus.o_overflow   = empty ? 1'b0 : headEntry[DATA_W];
    assign bus.o_full       = full;
    assign bus.o_empty      = empty;
    assign bus.o_count      = count_q;
    assign bus.o_ovf_sticky = sticky_q;

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
Downstream stage of the 12-bit signed ALU. It captures every valid ALU result together with its overflow flag into a small FIFO. It then presents the results to a consumer through a valid/ready handshake. The ALU has no backpressure, so this block absorbs bursts, drops results when full and counts those drops, and keeps overflow statistics for software and debug.

Parameters:
DATA_W, 12, result width; matches the ALU output width.
DEPTH, 8, FIFO entries; must be a power of 2 and at least 2; other values fail elaboration.
CNT_W, 8, width of the saturating drop and overflow counters.

Ports:
i_clk  input  1  clock
i_rst  input  1  reset
i_valid  input  1  result strobe from ALU o_valid
i_data  input  DATA_W  result from ALU o_data
i_overflow  input  1  overflow flag from ALU o_overflow
i_clr  input  1  clears the statistics (drop count, overflow count, sticky flag); does not flush the FIFO
o_valid  output  1  head entry available
i_ready  input  1  consumer accepts the head entry
o_data  output  DATA_W  head entry data
o_overflow  output  1  head entry overflow flag
o_full  output  1  FIFO holds DEPTH entries
o_empty  output  1  FIFO holds 0 entries
o_count  output  $clog2(DEPTH)+1  current occupancy
o_drop_cnt  output  CNT_W  results lost because the FIFO was full; saturating
o_ovf_cnt  output  CNT_W  accepted entries with overflow=1; saturating
o_ovf_sticky  output  1  set by any i_valid carrying i_overflow=1, including dropped results

Behaviour:
- Clock and reset (already decided): one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset: pointers and count go to 0. o_valid=0, o_empty=1, o_full=0, o_data=0, o_overflow=0, both counters 0, sticky flag 0. Memory contents are not reset.
- Reset mid-operation: all entries are discarded at that edge. Inputs presented in the reset cycle are ignored.
- Pop: pop = o_valid & i_ready. o_valid = !o_empty.
- Push: push = i_valid & (!o_full | pop). A full FIFO with a simultaneous pop accepts the push; count stays DEPTH and there is no drop.
- Drop: i_valid & o_full & !pop. The entry is discarded and o_drop_cnt increments.
- Output mode: first-word-fall-through. o_data and o_overflow show the head entry combinationally from registered state. When empty they are masked to 0.
- Latency: a result pushed at edge N appears on o_valid after edge N when the FIFO was empty. There is no same-cycle bypass. Pop is impossible while empty.
- Occupancy: count' = count + push - pop. o_full = (count == DEPTH). o_empty = (count == 0).
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
- Order: strict FIFO. Each stored entry is {overflow, data}.
- Counters: saturate at all-ones and never wrap. o_ovf_cnt increments only on push with i_overflow=1.
- i_clr: has priority. The counters and sticky flag go to 0 at that edge. Events in the same cycle are not counted. FIFO operation is unaffected.
- Invalid inputs: i_data and i_overflow are ignored when i_valid=0. Pushing with X data is legal; the bench checks only valid fields.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W=12 and the ALU opcode constants (ADD..ABSMAX, 3'b000..3'b111).
  - typedef alu_res_t = struct packed {logic ovf; logic [DATA_W-1:0] data;}.
- One sub-module: sat_counter (parameter CNT_W; inputs clr, inc; output count, saturating). It is instantiated twice, for drop and ovf.
- FIFO storage and pointers stay inline.

Test Plan:
- Reset, i_ready=0, push 0x7FF/ovf0, 0x800/ovf1, 0x001/ovf0 -> o_count=3, o_data=0x7FF, o_overflow=0, o_ovf_cnt=1, o_ovf_sticky=1, o_drop_cnt=0.
- Push 10 results with i_ready=0 (DEPTH=8) -> o_full=1, o_count=8, o_drop_cnt=2. Then i_ready=1 -> the first 8 values drain in order, and o_empty=1 after 8 cycles.
- FIFO full, then i_valid=1 and i_ready=1 in one cycle with data 0x123 -> o_count stays 8, o_drop_cnt unchanged, and 0x123 emerges as the 8th pop.
- CNT_W=2, FIFO full, 5 drops with i_overflow=1 -> o_drop_cnt=3 (saturated) and o_ovf_sticky=1, while o_ovf_cnt does not increase.
- i_clr asserted in the same cycle as a drop -> next cycle o_drop_cnt=0 and o_ovf_sticky=0, with o_count and head data unchanged.
- 5 entries stored, i_rst pulsed for one cycle while i_valid=1 -> next cycle o_empty=1, o_valid=0, o_data=0, all counters 0, and the input of the reset cycle is not stored.
